cfg_const_seq: RTL
==================

# cfg_const_seq

Configuration-constant sequencer. On a start request it walks a bank of `nslots` configuration slots and delivers one parameterized constant per slot (`base + index*stride`) to a downstream register bank over a valid/ready interface, then pulses `done`. It sits between the boot/control logic and any block whose constant configuration is loaded slot-by-slot rather than wired as a fixed literal.

## Interface

- `nbits`, 8, width of each constant word
- `nslots`, 4, number of slots to load; legal range ≥ 1
- `base`, 0, value for slot 0; truncated to `nbits`
- `stride`, 1, increment between consecutive slots; truncated to `nbits`

Ports:

- `clk`, input, 1, sole clock; all state changes on its rising edge
- `reset_n`, input, 1, asynchronous active-low reset
- `start`, input, 1, begin a load sequence; sampled only in IDLE
- `abort`, input, 1, synchronous abandon of an in-progress sequence
- `busy`, output, 1, high in SEND and DONE
- `done`, output, 1, one-cycle pulse after the final slot is accepted
- `out_val`, output, 1, slot transaction valid
- `out_rdy`, input, 1, downstream accepts the slot transaction
- `out_addr`, output, AW = max(1, $clog2(nslots)), slot index
- `out_data`, output, `nbits`, constant for `out_addr`

## Operation

- States: IDLE, SEND, DONE.
- IDLE:
  - `start`=1 → SEND, and the index is cleared to 0.
  - Otherwise the block stays in IDLE.
- SEND:
  - `out_val`=1, `out_addr`=index, `out_data`=(base + index*stride) mod 2^nbits.
  - The product and sum are computed at ≥ nbits+AW width, then truncated.
  - Transfer occurs when `out_val`&&`out_rdy`.
  - On transfer with index==nslots-1 → DONE. On transfer otherwise → index+1, stay in SEND.
  - No transfer: `out_addr`/`out_data` hold stable and `out_val` stays high (no retraction).
- DONE:
  - `done`=1 for exactly this cycle, then → IDLE unconditionally.
- `abort`=1 in SEND → IDLE next cycle, no `done` pulse, index cleared.
  - If `abort` and a transfer occur in the same cycle, the transfer counts downstream, but `abort` wins the state transition.
  - `abort` in IDLE or DONE has no effect.
- `start` in SEND or DONE is ignored; it is not queued.
- `start` and `abort` together in IDLE: `start` is honoured.
- Outputs outside SEND: `out_val`=0, and `out_addr`/`out_data` are driven to 0.
- `nslots`=1: a single transfer, then DONE.

## Timing

- Reset (asynchronous assert, released synchronously to `clk` by the system):
  - state=IDLE, index=0.
  - `busy`=0, `done`=0, `out_val`=0, `out_addr`=0, `out_data`=0.
- Reset asserted mid-sequence aborts immediately; no `done` pulse is issued.
- All outputs are decoded from registered state/index only; there is no combinational path from `start`, `abort` or `out_rdy` to any output.
- Latency with `out_rdy` held high:
  - `start` sampled at edge 0 → `out_val` high from edge 0.
  - One slot transfers per cycle.
  - `done` is high in the cycle after the last transfer.
  - Total: nslots+1 cycles from `start` to `done`, with IDLE re-entered one cycle later.
- Minimum `start`-to-`start` spacing: nslots+2 cycles.

## Structure

- Package `cfg_const_seq_pkg`: state enum `cfg_const_seq_state_t` {IDLE, SEND, DONE}.
- Sub-module `cfg_const_seq_gen`: purely combinational slot-value generator (index → `out_data`), parameterized by `nbits`/`nslots`/`base`/`stride`.
- Top level: the FSM and index counter.

## Test plan

- Basic sequence: nbits=8, nslots=4, base=8'h10, stride=3, `out_rdy`=1, pulse `start` → addr/data (0,10),(1,13),(2,16),(3,19) on consecutive cycles; `done` for one cycle next; `busy` low after.
- Wrap-around: base=8'hFE, stride=1, nslots=4 → data FE,FF,00,01.
- Backpressure: hold `out_rdy`=0 for 3 cycles on slot 1 → addr=1/data=13 stable with `out_val`=1 throughout; sequence completes with exactly 4 transfers.
- Start ignored while busy: pulse `start` during SEND and during DONE → no restart and no second sequence; IDLE reached after `done`.
- Abort: assert `abort` at slot 2 (with `out_rdy`=1) → slot 2 transfers, IDLE next cycle, `done` never pulses; a subsequent `start` restarts from addr 0.
- Async reset: drop `reset_n` mid-slot 1, between clock edges → all outputs 0 immediately; after release, `start` yields a full 4-slot sequence.

Source files
------------

// File: rtl/cfg_const_seq_pkg.sv
// Shared types for the configuration-constant sequencer.
// Holds the FSM state encoding and the slot-address width helper.
package cfg_const_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } cfg_const_seq_state_t;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_const_seq_gen.sv
// Combinational slot-value generator: data = base + idx*stride.
// Arithmetic is done wide enough for the product, then truncated.
module cfg_const_seq_gen
  import cfg_const_seq_pkg::*;
#(
  parameter int nbits  = 8,
  parameter int nslots = 4,
  parameter int base   = 0,
  parameter int stride = 1
) (
  input  logic [addr_w(nslots)-1:0] idx,
  output logic [nbits-1:0]          data
);

  localparam int aw = addr_w(nslots);
  localparam int ww = nbits + aw;

  localparam logic [nbits-1:0] bt = nbits'(base);
  localparam logic [nbits-1:0] st = nbits'(stride);
  localparam logic [ww-1:0]    bw = ww'(bt);
  localparam logic [ww-1:0]    sw = ww'(st);

  always_comb begin
    data = nbits'(bw + ww'(idx) * sw);
  end

endmodule

// File: rtl/cfg_const_seq.sv
// Configuration-constant sequencer: walks nslots slots on start,
// handing one constant per slot downstream, then pulses done.
module cfg_const_seq
  import cfg_const_seq_pkg::*;
#(
  parameter int nbits  = 8,
  parameter int nslots = 4,
  parameter int base   = 0,
  parameter int stride = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      out_val,
  input  logic                      out_rdy,
  output logic [addr_w(nslots)-1:0] out_addr,
  output logic [nbits-1:0]          out_data
);

  localparam int aw = addr_w(nslots);
  localparam logic [aw-1:0] last_idx = aw'(nslots - 1);

  cfg_const_seq_state_t state_q, state_d;
  logic [aw-1:0]        idx_q, idx_d;
  logic [nbits-1:0]     gen_data;
  logic                 xfer;

  cfg_const_seq_gen #(
    .nbits  (nbits),
    .nslots (nslots),
    .base   (base),
    .stride (stride)
  ) u_gen (
    .idx  (idx_q),
    .data (gen_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign xfer = (state_q == SEND) && out_rdy;

  // abort overrides the state move even when a transfer lands
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start) begin
          state_d = SEND;
          idx_d   = '0;
        end
      end
      (state_q == SEND): begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (xfer) begin
          if (idx_q == last_idx) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    out_val  = (state_q == SEND);
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    out_addr = out_val ? idx_q : '0;
    out_data = out_val ? gen_data : '0;
  end

endmodule
